// File: rtl/fpu_pkg.sv
// Shared constants and enums for the FP32 divider: IEEE field codes,
// special-case classification and the divider control states.
package fpu_pkg;
  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_INF  = 8'hFF;
  localparam logic [7:0]  EXP_ZERO = 8'h00;
  localparam logic [31:0] QNAN     = 32'h7FC00000;

  typedef enum logic [1:0] {SPC_NONE, SPC_NAN, SPC_INF, SPC_ZERO} spc_e;
  typedef enum logic [1:0] {IDLE, DIV, RND, DONE} state_e;
endpackage

// File: rtl/fpu_div_man_iter.sv
// Restoring mantissa divider: one quotient bit per step, remainder kept
// left-shifted so it never needs more than 25 bits.
module fpu_div_man_iter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        step_i,
  input  logic [23:0] ma_i,
  input  logic [23:0] mb_i,
  output logic [25:0] q_o,
  output logic        rem_nz_o
);
  logic [24:0] rem_q, rem_d, diff;
  logic [23:0] mb_q;
  logic [25:0] q_q, q_d;
  logic        ge;

  always_comb begin
    ge    = (rem_q >= {1'b0, mb_q});
    diff  = rem_q - {1'b0, mb_q};
    // After a subtract (or a failed compare) the remainder is below mb,
    // so bit 24 is always zero before the shift.
    rem_d = ge ? {diff[23:0], 1'b0} : {rem_q[23:0], 1'b0};
    q_d   = {q_q[24:0], ge};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q <= '0;
      mb_q  <= '0;
      q_q   <= '0;
    end else if (start_i) begin
      rem_q <= {1'b0, ma_i};
      mb_q  <= mb_i;
      q_q   <= '0;
    end else if (step_i) begin
      rem_q <= rem_d;
      q_q   <= q_d;
    end
  end

  assign q_o      = q_q;
  assign rem_nz_o = |rem_q;
endmodule

// File: rtl/fpu_div.sv
// Iterative FP32 divider: 26 restoring steps, then normalise/round, result
// held on a valid/ready output. Denormal inputs flush to zero.
module fpu_div
  import fpu_pkg::*;
#(
  parameter int SIZE_DATA = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_32_a,
  input  logic [SIZE_DATA-1:0] i_32_b,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_32_div,
  output state_e               o_state
);
  // Handshake: a transfer happens on any rising edge where valid and ready
  // are both high; o_valid/o_32_div stay stable until i_ready is seen.
  localparam int Q_BITS = 26;

  state_e            state_q;
  logic [4:0]        cnt_q;
  logic              sign_q, ready_q, valid_q;
  logic [7:0]        ea_q, eb_q;
  spc_e              spc_q, spc_d;
  logic [31:0]       res_q, res_d;
  logic              accept, rem_nz;
  logic [25:0]       q;
  logic [23:0]       man;
  logic [24:0]       man_r;
  logic              guard, sticky, inc;
  logic signed [9:0] e_base, e_norm, e_fin;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign accept = (state_q == IDLE) && i_valid;

  always_comb begin
    a_zero = (i_32_a[30:23] == EXP_ZERO);
    b_zero = (i_32_b[30:23] == EXP_ZERO);
    a_inf  = (i_32_a[30:23] == EXP_INF) && (i_32_a[22:0] == 23'd0);
    b_inf  = (i_32_b[30:23] == EXP_INF) && (i_32_b[22:0] == 23'd0);
    a_nan  = (i_32_a[30:23] == EXP_INF) && (i_32_a[22:0] != 23'd0);
    b_nan  = (i_32_b[30:23] == EXP_INF) && (i_32_b[22:0] != 23'd0);
    spc_d  = SPC_NONE;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) spc_d = SPC_NAN;
    else if (a_inf || b_zero)                                      spc_d = SPC_INF;
    else if (a_zero || b_inf)                                      spc_d = SPC_ZERO;
  end

  // The hidden one is always set, so mb is never zero even for flushed inputs.
  fpu_div_man_iter u_iter (
    .clk_i    (i_clk),
    .rst_i    (i_rst),
    .start_i  (accept),
    .step_i   (state_q == DIV),
    .ma_i     ({1'b1, i_32_a[22:0]}),
    .mb_i     ({1'b1, i_32_b[22:0]}),
    .q_o      (q),
    .rem_nz_o (rem_nz)
  );

  always_comb begin
    e_base = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
    if (q[25]) begin
      man    = q[25:2];
      guard  = q[1];
      sticky = q[0] | rem_nz;
      e_norm = e_base;
    end else begin
      man    = q[24:1];
      guard  = q[0];
      sticky = rem_nz;
      e_norm = e_base - 10'sd1;
    end
    inc   = guard & (sticky | man[0]);
    man_r = {1'b0, man} + {24'd0, inc};
    // A carry-out leaves man_r[22:0] at zero, i.e. mantissa 1.0.
    e_fin = man_r[24] ? e_norm + 10'sd1 : e_norm;
    case (spc_q)
      SPC_NAN:  res_d = QNAN;
      SPC_INF:  res_d = {sign_q, EXP_INF, 23'd0};
      SPC_ZERO: res_d = {sign_q, EXP_ZERO, 23'd0};
      default: begin
        if (e_fin >= 10'sd255)   res_d = {sign_q, EXP_INF, 23'd0};
        else if (e_fin <= 10'sd0) res_d = {sign_q, EXP_ZERO, 23'd0};
        else                      res_d = {sign_q, e_fin[7:0], man_r[22:0]};
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      ea_q    <= '0;
      eb_q    <= '0;
      spc_q   <= SPC_NONE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          sign_q  <= i_32_a[31] ^ i_32_b[31];
          ea_q    <= i_32_a[30:23];
          eb_q    <= i_32_b[30:23];
          spc_q   <= spc_d;
          cnt_q   <= 5'(Q_BITS - 1);
          ready_q <= 1'b0;
          state_q <= DIV;
        end
        DIV: begin
          if (cnt_q == 5'd0) state_q <= RND;
          else               cnt_q   <= cnt_q - 5'd1;
        end
        RND: begin
          res_q   <= res_d;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: if (i_ready) begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_32_div = res_q;
  assign o_state  = state_q;
endmodule

// File: tb/tb_fpu_div.sv
// Bench for fpu_div: table and random operands through a scoreboard queue,
// plus latency, backpressure, issue-interval and mid-operation reset scenarios.
module tb_fpu_div;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        o_ready, o_valid;
  logic [31:0] o_32_div;
  state_e      st;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];

  // Cycle 1 is the accepting edge; the result is due on cycle 28.
  localparam int LAT = 28;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fpu_div dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_32_a   (a),
    .i_32_b   (b),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_32_div (o_32_div),
    .o_state  (st)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [31:0] da, input logic [31:0] db,
                          input logic [31:0] de, output int acc_cyc);
    int w = 0;
    while (!o_ready && w < 60) begin
      tick();
      w++;
    end
    a = da;
    b = db;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    acc_cyc = cyc;
    exp_q.push_back(de);
  endtask

  task automatic wait_result(output logic [31:0] got, output int lat, output logic ok);
    lat = 1;
    while (!o_valid && lat < 60) begin
      tick();
      lat++;
    end
    ok  = o_valid;
    got = o_32_div;
  endtask

  task automatic consume();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", o_ready); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    checks++; if (o_32_div !== 32'h0) begin failures++; $display("FAIL reset_result got=%h want=00000000", o_32_div); end
    checks++; if (st !== IDLE) begin failures++; $display("FAIL reset_state got=%0d want=%0d", st, IDLE); end
  endtask

  task automatic run_table(input string name, input logic [31:0] ta[], input logic [31:0] tb[],
                           input logic [31:0] te[]);
    logic [31:0] got, want;
    int lat, acc;
    logic ok;
    for (int i = 0; i < ta.size(); i++) begin
      drive_op(ta[i], tb[i], te[i], acc);
      wait_result(got, lat, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL %s_timeout[%0d] o_valid=%b want=1", name, i, ok); end
      want = exp_q.pop_front();
      checks++; if (got !== want) begin failures++; $display("FAIL %s[%0d] %h/%h got=%h want=%h", name, i, ta[i], tb[i], got, want); end
      checks++; if (lat !== LAT) begin failures++; $display("FAIL %s_latency[%0d] got=%0d want=%0d", name, i, lat, LAT); end
      consume();
      checks++; if ({o_valid, o_ready} !== 2'b01) begin failures++; $display("FAIL %s_release[%0d] valid,ready got=%b want=01", name, i, {o_valid, o_ready}); end
    end
  endtask

  task automatic test_basic();
    logic [31:0] ta[] = '{32'h40C00000, 32'hC0C00000, 32'h3F800000, 32'h3F800000};
    logic [31:0] tb[] = '{32'h40000000, 32'h40000000, 32'h40400000, 32'h3F800000};
    logic [31:0] te[] = '{32'h40400000, 32'hC0400000, 32'h3EAAAAAB, 32'h3F800000};
    run_table("basic", ta, tb, te);
  endtask

  task automatic test_specials();
    logic [31:0] ta[] = '{32'h3F800000, 32'h00000000, 32'h00000000, 32'h7F800000, 32'h7F800001,
                          32'hFFC00000, 32'hFF800000, 32'h80000000, 32'h3F800000, 32'h00000001};
    logic [31:0] tb[] = '{32'h00000000, 32'h00000000, 32'h3F800000, 32'h7F800000, 32'h3F800000,
                          32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hFF800000, 32'h3F800000};
    logic [31:0] te[] = '{32'h7F800000, 32'h7FC00000, 32'h00000000, 32'h7FC00000, 32'h7FC00000,
                          32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h80000000, 32'h00000000};
    run_table("special", ta, tb, te);
  endtask

  task automatic test_range();
    logic [31:0] ta[] = '{32'h7F000000, 32'h00800000};
    logic [31:0] tb[] = '{32'h00800000, 32'h7F000000};
    logic [31:0] te[] = '{32'h7F800000, 32'h00000000};
    run_table("range", ta, tb, te);
  endtask

  // Dividing by a power of two is exact: only sign and exponent change.
  task automatic test_random_pow2();
    logic [31:0] ta[] = new[6];
    logic [31:0] tb[] = new[6];
    logic [31:0] te[] = new[6];
    for (int i = 0; i < 6; i++) begin
      logic       sa, sb;
      int         ea, eb;
      logic [22:0] fa;
      sa = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      ea = $urandom_range(64, 190);
      eb = $urandom_range(64, 190);
      fa = 23'($urandom_range(0, 32'h7FFFFF));
      ta[i] = {sa, 8'(ea), fa};
      tb[i] = {sb, 8'(eb), 23'd0};
      te[i] = {sa ^ sb, 8'(ea - eb + 127), fa};
    end
    run_table("pow2", ta, tb, te);
  endtask

  task automatic test_backpressure();
    logic [31:0] got, want;
    int lat, acc;
    logic ok;
    drive_op(32'h40C00000, 32'h40000000, 32'h40400000, acc);
    wait_result(got, lat, ok);
    want = exp_q.pop_front();
    checks++; if (got !== want) begin failures++; $display("FAIL bp_result got=%h want=%h", got, want); end
    a = 32'h3F800000;
    b = 32'h40400000;
    i_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (o_32_div !== want) begin failures++; $display("FAIL bp_hold[%0d] got=%h want=%h", i, o_32_div, want); end
      checks++; if ({o_valid, o_ready} !== 2'b10) begin failures++; $display("FAIL bp_flags[%0d] valid,ready got=%b want=10", i, {o_valid, o_ready}); end
    end
    i_valid = 1'b0;
    consume();
    checks++; if ({o_valid, o_ready} !== 2'b01) begin failures++; $display("FAIL bp_release valid,ready got=%b want=01", {o_valid, o_ready}); end
    repeat (3) tick();
    checks++; if (st !== IDLE || o_valid !== 1'b0) begin failures++; $display("FAIL bp_ignored state=%0d valid=%b want state=%0d valid=0", st, o_valid, IDLE); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, want;
    int lat, acc1, acc2;
    logic ok;
    drive_op(32'h3F800000, 32'h3F800000, 32'h3F800000, acc1);
    wait_result(got, lat, ok);
    want = exp_q.pop_front();
    checks++; if (got !== want) begin failures++; $display("FAIL b2b_first got=%h want=%h", got, want); end
    consume();
    drive_op(32'hC0C00000, 32'h40000000, 32'hC0400000, acc2);
    checks++; if (acc2 - acc1 !== 29) begin failures++; $display("FAIL b2b_interval got=%0d want=29", acc2 - acc1); end
    wait_result(got, lat, ok);
    want = exp_q.pop_front();
    checks++; if (got !== want) begin failures++; $display("FAIL b2b_second got=%h want=%h", got, want); end
    checks++; if (lat !== LAT) begin failures++; $display("FAIL b2b_latency got=%0d want=%0d", lat, LAT); end
    consume();
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, want;
    int lat, acc;
    logic ok;
    drive_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, acc);
    repeat (11) tick();
    checks++; if (st !== DIV) begin failures++; $display("FAIL rstmid_in_div state=%0d want=%0d", st, DIV); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({o_valid, o_ready} !== 2'b01) begin failures++; $display("FAIL rstmid_async valid,ready got=%b want=01", {o_valid, o_ready}); end
    exp_q.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    checks++; if (st !== IDLE) begin failures++; $display("FAIL rstmid_state got=%0d want=%0d", st, IDLE); end
    drive_op(32'h40C00000, 32'h40000000, 32'h40400000, acc);
    wait_result(got, lat, ok);
    want = exp_q.pop_front();
    checks++; if (got !== want) begin failures++; $display("FAIL rstmid_after got=%h want=%h", got, want); end
    checks++; if (lat !== LAT) begin failures++; $display("FAIL rstmid_latency got=%0d want=%0d", lat, LAT); end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_specials();
    test_range();
    test_random_pow2();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpu_div.md
Name: fpu_div

Overview:
- Iterative IEEE-754 single-precision divider for the FFT datapath. It is the inverse-operation companion to the combinational FP32 multiplier.
- Uses a restoring mantissa division, one quotient bit per clock. The fixed-latency result is presented on a valid/ready handshake.
- Intended for twiddle/normalisation scaling, where throughput of one result per ~29 cycles is acceptable.
- Number handling matches the multiplier: denormals flushed to zero, no exception flags.

Parameters:
- SIZE_DATA, 32, operand/result width. Only 32 (binary32) is supported.
- Q_BITS, 26, quotient bits generated: 24 mantissa + 1 normalisation + 1 guard. Localparam, not overridable.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  operands valid.
- o_ready  out  1  divider idle, can accept.
- i_32_a  in  32  dividend.
- i_32_b  in  32  divisor.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_32_div  out  32  quotient a/b.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high (i_rst), applied to all state.
  - State goes to IDLE; o_ready=1, o_valid=0, o_32_div=0.
  - An operation in flight is discarded silently.
- States:
  - IDLE: o_ready=1. Accepts on i_valid&o_ready and latches sign = a[31]^b[31], exponents, mantissas {1,frac}, and a special-case code. Goes to DIV; the counter loads Q_BITS-1.
  - DIV: one restoring step per cycle: rem = rem - mb if rem >= mb, set q bit, then rem <<= 1. Initial rem = ma. Goes to RND when the counter reaches 0 (26 cycles).
  - RND: normalise, round, exponent adjust, special override, register o_32_div. Goes to DONE.
  - DONE: o_valid=1 and o_32_div held stable. Returns to IDLE on i_ready.
- Handshake and latency:
  - o_ready is low in DIV, RND and DONE; i_valid there is ignored.
  - o_valid rises exactly 28 cycles after the accepting edge, for all operands including specials. Specials still traverse DIV.
  - A new operation cannot be accepted in the same cycle the result is consumed. Minimum issue interval is 29 cycles.
- Normalise:
  - If q[25]=1: man = q[25:2], guard = q[1], sticky = q[0] | (rem != 0).
  - Else: man = q[24:1], guard = q[0], sticky = (rem != 0), exponent -1.
- Round to nearest even:
  - Increment if guard & (sticky | man[0]).
  - Mantissa carry-out sets man = 0x800000 and exponent +1.
- Exponent:
  - Computed in 10-bit signed: e = ea - eb + 127, then normalise/round adjustments.
  - e >= 255 gives ±inf (exp=0xFF, frac=0).
  - e <= 0 gives ±0 (flush, no denormal output).
- Specials (priority order, override in RND):
  - Either operand exp=0xFF with frac!=0, 0/0, or inf/inf: NaN 0x7FC00000, sign forced 0.
  - a=inf or b=0: ±inf.
  - a=0 or b=inf: ±0.
  - Operands with exp=0 are treated as zero regardless of fraction.

Decomposition:
- Package fpu_pkg holds:
  - EXP_BIAS=127, EXP_INF=8'hFF, EXP_ZERO=8'h00, QNAN=32'h7FC00000.
  - Special-case enum {SPC_NONE, SPC_NAN, SPC_INF, SPC_ZERO}.
  - FSM state enum {IDLE, DIV, RND, DONE}.
- Sub-module fpu_div_man_iter: 24/25-bit restoring divider datapath.
  - Inputs: start, step; ma, mb.
  - Outputs: q[25:0], rem_nz.
  - The top-level FSM drives the counter and steps.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) -> 0x40400000 at cycle 28 after accept. 0xC0C00000 / 0x40000000 -> 0xC0400000.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (round-up via sticky). 0x3F800000 / 0x3F800000 -> 0x3F800000.
- Specials:
  - 0x3F800000 / 0x00000000 -> 0x7F800000.
  - 0x00000000 / 0x00000000 -> 0x7FC00000.
  - 0x00000000 / 0x3F800000 -> 0x00000000.
  - 0x7F800000 / 0x7F800000 -> 0x7FC00000.
  - All at the same 28-cycle latency.
- Range limits: 0x7F000000 / 0x00800000 -> 0x7F800000. 0x00800000 / 0x7F000000 -> 0x00000000.
- Backpressure: hold i_ready=0 for 10 cycles after o_valid. Required: o_32_div stable, o_ready=0, and a second i_valid is ignored. On the i_ready pulse, o_valid drops the next cycle and o_ready=1.
- Reset mid-operation: assert i_rst at DIV cycle 12. Required: o_valid=0 and o_ready=1 immediately (asynchronous). A subsequent 6/2 completes correctly to 0x40400000.
